// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    // Width of the iteration counter, which counts DIVIDEND_W-1 down to 0.
    function automatic int unsigned cnt_width(int unsigned dividend_w);
        return $clog2(dividend_w);
    endfunction

    // Magnitude of a width-bit two's-complement value, one bit wider so MIN is exact.
    function automatic logic [64:0] abs_ext(logic [63:0] value, int unsigned width);
        logic [64:0] ext;
        logic        sign;
        sign = value[width-1];
        for (int unsigned i = 0; i < 64; i++) begin
            ext[i] = (i < width) ? value[i] : sign;
        end
        ext[64] = sign;
        return sign ? (~ext + 65'd1) : ext;
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the signed divider.
interface seq_signed_divider_if #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_div_core_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, subtract.
module seq_div_core_step #(
    parameter int unsigned DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0] rem_i,
    input  logic               msb_i,
    input  logic [DIVISOR_W:0] dvs_i,
    output logic [DIVISOR_W:0] rem_o,
    output logic               q_bit_o
);
    logic [DIVISOR_W:0] shifted;
    // The partial remainder is always below |divisor|, so its top bit is zero.
    logic               unused_rem_msb;

    assign unused_rem_msb = rem_i[DIVISOR_W];

    always_comb begin
        shifted = {rem_i[DIVISOR_W-1:0], msb_i};
        q_bit_o = (shifted >= dvs_i);
        rem_o   = q_bit_o ? (shifted - dvs_i) : shifted;
    end
endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (restoring, one quotient bit per clock, then sign fix).
// Optional zero-operand shortcut enabled by defining SEQ_DIV_FAST_BYPASS_EN.
module seq_signed_divider
    import seq_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);
    localparam int unsigned CntW = cnt_width(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] MinMag = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVISOR_W:0]    dvs_q, dvs_d;
    logic                  dvd_neg_q, dvd_neg_d;
    logic                  dvs_neg_q, dvs_neg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    logic [DIVIDEND_W:0]   dvd_abs;
    logic [DIVISOR_W:0]    dvs_abs;
    logic                  unused_dvd_top;
    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;
    logic [DIVIDEND_W-1:0] q_fix;
    logic [DIVISOR_W-1:0]  r_fix;

    assign dvd_abs = (DIVIDEND_W+1)'(abs_ext(64'(bus.dividend), DIVIDEND_W));
    assign dvs_abs = (DIVISOR_W+1)'(abs_ext(64'(bus.divisor), DIVISOR_W));
    // |MIN| = 2^(W-1) still fits in W unsigned bits, so the extra bit is never set.
    assign unused_dvd_top = dvd_abs[DIVIDEND_W];

    seq_div_core_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i   (rem_q),
        .msb_i   (quo_q[DIVIDEND_W-1]),
        .dvs_i   (dvs_q),
        .rem_o   (step_rem),
        .q_bit_o (step_q)
    );

    // With a zero divisor the remainder path naturally yields dividend[DIVISOR_W-1:0].
    always_comb begin
        q_fix = (dvs_q == '0)              ? '1 :
                (dvd_neg_q ^ dvs_neg_q)    ? -quo_q : quo_q;
        r_fix = dvd_neg_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dvd_neg_d = bus.dividend[DIVIDEND_W-1];
                    dvs_neg_d = bus.divisor[DIVISOR_W-1];
                    dvs_d     = dvs_abs;
                    quo_d     = dvd_abs[DIVIDEND_W-1:0];
                    rem_d     = '0;
                    cnt_d     = CntW'(DIVIDEND_W - 1);
                    busy_d    = 1'b1;
                    state_d   = StCalc;
`ifdef SEQ_DIV_FAST_BYPASS_EN
                    if ((bus.divisor == '0) || (bus.dividend == '0)) begin
                        quo_d   = '0;
                        rem_d   = dvd_abs[DIVISOR_W:0];
                        state_d = StFix;
                    end
`endif
                end
            end
            StCalc: begin
                rem_d = step_rem;
                quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFix: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                dbz_d       = (dvs_q == '0);
                ovf_d       = dvd_neg_q && dvs_neg_q && (dvs_q == (DIVISOR_W+1)'(1))
                              && (quo_q == MinMag);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed + random bench for seq_signed_divider against an arithmetic reference model.
module tb_seq_signed_divider;
    localparam int unsigned W  = 16;
    localparam int unsigned V  = 8;
    localparam int          NV = 12;

    typedef struct {
        int           cyc;
        logic [W-1:0] q;
        logic [V-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    bit   checking = 0;
    int   target = 0;
    exp_t exp_q[$];
    exp_t last;
    exp_t cmp_e;

    seq_signed_divider_if #(.DIVIDEND_W(W), .DIVISOR_W(V)) bus ();

    seq_signed_divider #(
        .DIVIDEND_W (W),
        .DIVISOR_W  (V)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Truncating signed division with the defined zero-divisor and MIN/-1 results.
    function automatic void model(input longint a, input longint b, output logic [W-1:0] q,
                                  output logic [V-1:0] r, output logic dbz, output logic ovf);
        longint qq, rr;
        logic signed [V-1:0] lo;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            lo  = a[V-1:0];
            qq  = -1;
            rr  = lo;
            dbz = 1'b1;
        end else if (a == -(longint'(1) << (W - 1)) && b == -1) begin
            qq  = a;
            rr  = 0;
            ovf = 1'b1;
        end else begin
            qq = a / b;
            rr = a % b;
        end
        q = qq[W-1:0];
        r = rr[V-1:0];
    endfunction

    task automatic clear_expect();
        exp_q.delete();
        last.cyc = 0;
        last.q   = '0;
        last.r   = '0;
        last.dbz = 1'b0;
        last.ovf = 1'b0;
    endtask

    // Called at a negedge while the DUT is idle (or in its done cycle).
    task automatic issue(input longint a, input longint b);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a[W-1:0];
        bus.divisor  = b[V-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        model(a, b, e.q, e.r, e.dbz, e.ovf);
        e.cyc = cyc + W + 1;
`ifdef SEQ_DIV_FAST_BYPASS_EN
        if (b == 0 || a == 0) e.cyc = cyc + 1;
`endif
        exp_q.push_back(e);
        target = e.cyc;
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        while (cyc < target) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 clear_expect();
        @(negedge clk);
        rst_n = 1'b1;
        chk("busy_after_reset", 64'(bus.busy), 64'(0));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (exp_q.size() != 0 && cyc == exp_q[0].cyc) begin
                cmp_e = exp_q.pop_front();
                chk("done_pulse", 64'(bus.done), 64'(1));
                chk("busy_in_done", 64'(bus.busy), 64'(0));
                chk("quotient", 64'(bus.quotient), 64'(cmp_e.q));
                chk("remainder", 64'(bus.remainder), 64'(cmp_e.r));
                chk("div_by_zero", 64'(bus.div_by_zero), 64'(cmp_e.dbz));
                chk("overflow", 64'(bus.overflow), 64'(cmp_e.ovf));
                last = cmp_e;
            end else begin
                chk("no_done", 64'(bus.done), 64'(0));
                chk("quotient_held", 64'(bus.quotient), 64'(last.q));
                chk("remainder_held", 64'(bus.remainder), 64'(last.r));
                chk("flags_held", 64'({bus.div_by_zero, bus.overflow}),
                    64'({last.dbz, last.ovf}));
            end
        end
    end

    initial begin
        longint       tv_a [NV] = '{100, -100, 100, -100, -32768, 55, 0, -300, 127, -128, 32767, -1};
        longint       tv_b [NV] = '{7, 7, -7, -7, -1, 0, 5, 0, -128, -128, 1, 3};
        longint       tv_q [NV] = '{14, -14, -14, 14, -32768, -1, 0, -1, 0, 1, 32767, 0};
        longint       tv_r [NV] = '{2, -2, 2, -2, 0, 55, 0, -44, 127, 0, 0, -1};
        bit           tv_z [NV] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        bit           tv_o [NV] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        logic [W-1:0] mq, eq;
        logic [V-1:0] mr, er;
        logic         mz, mo;
        logic [W-1:0] ra;
        logic [V-1:0] rb;
        int           nb;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1 clear_expect();
        checking = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_quotient", 64'(bus.quotient), 64'(0));

        // Pin the model to hand-computed results.
        for (int i = 0; i < NV; i++) begin
            model(tv_a[i], tv_b[i], mq, mr, mz, mo);
            eq = tv_q[i][W-1:0];
            er = tv_r[i][V-1:0];
            chk("model_q", 64'(mq), 64'(eq));
            chk("model_r", 64'(mr), 64'(er));
            chk("model_flags", 64'({mz, mo}), 64'({tv_z[i], tv_o[i]}));
        end

        // 100/7: latency and busy duration.
        @(negedge clk);
        issue(tv_a[0], tv_b[0]);
        wait_done(nb);
        chk("busy_cycles", 64'(nb), 64'(W + 1));

        for (int i = 1; i < NV; i++) begin
            @(negedge clk);
            issue(tv_a[i], tv_b[i]);
            wait_done(nb);
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        issue(200, 9);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(7);
        bus.divisor  = V'(1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(nb);

        // Back-to-back: second start in the done cycle.
        @(negedge clk);
        issue(-77, 5);
        wait_done(nb);
        issue(1000, -128);
        wait_done(nb);

        // Reset mid-operation aborts with no done, then a fresh op completes.
        @(negedge clk);
        issue(12345, 11);
        repeat (5) @(negedge clk);
        do_reset();
        repeat (W + 5) @(negedge clk);
        issue(12345, 11);
        wait_done(nb);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = V'($urandom);
            if (i % 10 == 3) rb = '0;
            if (i % 10 == 7) begin
                ra = {1'b1, {(W-1){1'b0}}};
                rb = '1;
            end
            @(negedge clk);
            issue(longint'($signed(ra)), longint'($signed(rb)));
            wait_done(nb);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
